mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: sequences word, byte and indirect
// loads/stores over a handshaked memory port and stalls the pipeline meanwhile.
module mem_access_ctrl #(
    parameter bit ALIGN_WORD = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  op,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    output logic [15:0] rdata_out,
    output logic [15:0] ldb_out,
    output logic [15:0] addr_out,
    output logic        stall,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    localparam logic [2:0] OP_LDW = 3'b001;
    localparam logic [2:0] OP_LDB = 3'b010;
    localparam logic [2:0] OP_LDI = 3'b011;
    localparam logic [2:0] OP_STW = 3'b100;
    localparam logic [2:0] OP_STB = 3'b101;
    localparam logic [2:0] OP_STI = 3'b110;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic        valid_op, accept, indirect_q, load_q, final_resp;
    logic        read_d, write_d, done_d;
    logic [1:0]  be_d;
    logic [15:0] address_d, wdata_d, rdata_d, ldb_d, addr_out_d;
    logic [7:0]  sel_byte;

    function automatic logic [15:0] word_addr(input logic [15:0] a);
        word_addr = ALIGN_WORD ? {a[15:1], 1'b0} : a;
    endfunction

    assign valid_op   = (op != 3'b000) && (op != 3'b111);
    assign accept     = (state == IDLE) && req_valid && valid_op;
    assign stall      = req_valid && valid_op && (state != DONE);
    assign indirect_q = (op_q == OP_LDI) || (op_q == OP_STI);
    assign load_q     = (op_q == OP_LDW) || (op_q == OP_LDB) || (op_q == OP_LDI);
    assign final_resp = mem_resp && (((state == ACC1) && !indirect_q) || (state == ACC2));
    assign sel_byte   = mem_address[0] ? mem_rdata[15:8] : mem_rdata[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = ACC1;
            ACC1: if (mem_resp) state_nxt = indirect_q ? ACC2 : DONE;
            ACC2: if (mem_resp) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs; anything not touched holds.
    always_comb begin
        read_d     = mem_read;
        write_d    = mem_write;
        be_d       = mem_byte_enable;
        address_d  = mem_address;
        wdata_d    = mem_wdata;
        done_d     = 1'b0;
        rdata_d    = rdata_out;
        ldb_d      = ldb_out;
        addr_out_d = addr_out;
        case (state)
            IDLE: begin
                if (accept) begin
                    read_d  = (op == OP_LDW) || (op == OP_LDB) || (op == OP_LDI) || (op == OP_STI);
                    write_d = (op == OP_STW) || (op == OP_STB);
                    if ((op == OP_LDB) || (op == OP_STB)) begin
                        address_d = addr_in;
                        be_d      = addr_in[0] ? 2'b10 : 2'b01;
                    end else begin
                        address_d = word_addr(addr_in);
                        be_d      = 2'b11;
                    end
                    wdata_d = (op == OP_STB) ? {2{wdata_in[7:0]}} : wdata_in;
                end
            end
            ACC1: begin
                // Pointer fetched: retarget the request to the pointed-to word.
                if (mem_resp && indirect_q) begin
                    address_d = word_addr(mem_rdata);
                    be_d      = 2'b11;
                    read_d    = (op_q == OP_LDI);
                    write_d   = (op_q == OP_STI);
                end
            end
            default: ;
        endcase
        if (final_resp) begin
            read_d     = 1'b0;
            write_d    = 1'b0;
            done_d     = 1'b1;
            addr_out_d = mem_address;
            if (load_q)
                rdata_d = mem_rdata;
            if (op_q == OP_LDB)
                ldb_d = {{8{sel_byte[7]}}, sel_byte};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q            <= 3'b000;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= 2'b00;
            mem_address     <= 16'h0000;
            mem_wdata       <= 16'h0000;
            done            <= 1'b0;
            rdata_out       <= 16'h0000;
            ldb_out         <= 16'h0000;
            addr_out        <= 16'h0000;
        end else begin
            if (accept)
                op_q <= op;
            mem_read        <= read_d;
            mem_write       <= write_d;
            mem_byte_enable <= be_d;
            mem_address     <= address_d;
            mem_wdata       <= wdata_d;
            done            <= done_d;
            rdata_out       <= rdata_d;
            ldb_out         <= ldb_d;
            addr_out        <= addr_out_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// accesses against a word/byte memory model with randomized response latency.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [15:0] addr_in = 16'h0;
    logic [15:0] wdata_in = 16'h0;
    logic        mem_read, mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address, mem_wdata;
    logic        mem_resp = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] rdata_out, ldb_out, addr_out;
    logic        stall, done;

    mem_access_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .op(op),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata), .rdata_out(rdata_out), .ldb_out(ldb_out),
        .addr_out(addr_out), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int viol = 0;
    int resp_delay = 0;
    int wait_cnt = 0;
    bit spurious = 0;
    bit held = 0;
    logic [15:0] h_addr, h_wdata;
    logic [1:0]  h_be;
    logic        h_read, h_write;
    logic [15:0] mem [65536];

    int          r_stall, r_done;
    bit          r_timeout, r_seen, r_saw_write;
    logic [15:0] r_first_addr, r_last_addr, r_last_wdata;
    logic [1:0]  r_last_be;
    logic [15:0] exp_rdata, exp_ldb;

    // Memory responder and handshake protocol monitor.
    always @(negedge clk) begin
        mem_resp = 1'b0;
        if (!rst_n) begin
            wait_cnt = 0;
            held = 0;
        end else begin
            if (mem_read && mem_write) viol++;
            if (held && !(mem_read || mem_write)) viol++;
            if (held && (mem_read || mem_write) &&
                (mem_address !== h_addr || mem_wdata !== h_wdata || mem_byte_enable !== h_be ||
                 mem_read !== h_read || mem_write !== h_write)) viol++;
            if (mem_read || mem_write) begin
                if (wait_cnt >= resp_delay) begin
                    mem_resp = 1'b1;
                    wait_cnt = 0;
                    held = 0;
                    if (mem_read)
                        mem_rdata = mem[mem_address];
                    else begin
                        if (mem_byte_enable[0]) mem[mem_address][7:0]  = mem_wdata[7:0];
                        if (mem_byte_enable[1]) mem[mem_address][15:8] = mem_wdata[15:8];
                    end
                end else begin
                    wait_cnt++;
                    held = 1;
                    h_addr = mem_address; h_wdata = mem_wdata; h_be = mem_byte_enable;
                    h_read = mem_read; h_write = mem_write;
                end
            end else begin
                wait_cnt = 0;
                held = 0;
            end
            if (spurious) mem_resp = 1'b1;
        end
    end

    task automatic run_access(input logic [2:0] o, input logic [15:0] a, input logic [15:0] w,
                              input int dly, input bit scramble);
        bit seen_done = 0;
        int post = 0;
        r_stall = 0; r_done = 0; r_seen = 0; r_saw_write = 0;
        r_first_addr = 16'h0; r_last_addr = 16'h0; r_last_wdata = 16'h0; r_last_be = 2'b00;
        resp_delay = dly;
        @(negedge clk);
        req_valid = 1'b1; op = o; addr_in = a; wdata_in = w;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (stall) r_stall++;
            if (mem_read || mem_write) begin
                if (!r_seen) r_first_addr = mem_address;
                r_seen = 1;
                if (mem_write) r_saw_write = 1;
                r_last_addr = mem_address; r_last_be = mem_byte_enable; r_last_wdata = mem_wdata;
            end
            if (done) begin
                r_done++;
                seen_done = 1;
                req_valid = 1'b0; op = 3'b000;
            end
            if (seen_done) post++;
            if (post == 3) break;
            @(negedge clk);
            if (scramble && !seen_done) begin
                addr_in = 16'($urandom); wdata_in = 16'($urandom);
            end
        end
        r_timeout = !seen_done;
        req_valid = 1'b0; op = 3'b000;
    endtask

    task automatic test_reset;
        #1;
        n_checks++; if ({mem_read, mem_write, done, stall} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {mem_read, mem_write, done, stall}); end
        n_checks++; if ({rdata_out, ldb_out, addr_out, mem_address, mem_wdata, mem_byte_enable} !== 82'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h %h %h %h %h %b expected all zero", rdata_out, ldb_out, addr_out, mem_address, mem_wdata, mem_byte_enable); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ldw;
        mem[16'h3000] = 16'hBEEF;
        run_access(3'b001, 16'h3001, 16'h0000, 2, 0);
        n_checks++; if (r_timeout) begin n_fail++; $display("[TB] FAIL ldw_timeout: got no done expected done"); end
        n_checks++; if (r_first_addr !== 16'h3000) begin n_fail++; $display("[TB] FAIL ldw_mem_address: got %h expected 3000", r_first_addr); end
        n_checks++; if (r_last_be !== 2'b11) begin n_fail++; $display("[TB] FAIL ldw_be: got %b expected 11", r_last_be); end
        n_checks++; if (rdata_out !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL ldw_rdata: got %h expected beef", rdata_out); end
        n_checks++; if (addr_out !== 16'h3000) begin n_fail++; $display("[TB] FAIL ldw_addr_out: got %h expected 3000", addr_out); end
        n_checks++; if (r_done !== 1) begin n_fail++; $display("[TB] FAIL ldw_done_pulses: got %0d expected 1", r_done); end
        n_checks++; if (r_stall !== 4) begin n_fail++; $display("[TB] FAIL ldw_stall_cycles: got %0d expected 4", r_stall); end
    endtask

    task automatic test_ldb;
        mem[16'h2005] = 16'h80FF;
        run_access(3'b010, 16'h2005, 16'h0000, 0, 0);
        n_checks++; if (r_last_be !== 2'b10) begin n_fail++; $display("[TB] FAIL ldb_be: got %b expected 10", r_last_be); end
        n_checks++; if (ldb_out !== 16'hFF80) begin n_fail++; $display("[TB] FAIL ldb_out: got %h expected ff80", ldb_out); end
        n_checks++; if (addr_out !== 16'h2005) begin n_fail++; $display("[TB] FAIL ldb_addr_out: got %h expected 2005", addr_out); end
        n_checks++; if (r_stall !== 2 || r_done !== 1) begin n_fail++; $display("[TB] FAIL ldb_timing: got stall %0d done %0d expected 2 1", r_stall, r_done); end
    endtask

    task automatic test_stb;
        mem[16'h2004] = 16'hA55A;
        run_access(3'b101, 16'h2004, 16'h1234, 1, 0);
        n_checks++; if (!r_saw_write) begin n_fail++; $display("[TB] FAIL stb_write: got no mem_write expected mem_write"); end
        n_checks++; if (r_last_be !== 2'b01) begin n_fail++; $display("[TB] FAIL stb_be: got %b expected 01", r_last_be); end
        n_checks++; if (r_last_wdata !== 16'h3434) begin n_fail++; $display("[TB] FAIL stb_wdata: got %h expected 3434", r_last_wdata); end
        n_checks++; if (rdata_out !== 16'h80FF) begin n_fail++; $display("[TB] FAIL stb_rdata_kept: got %h expected 80ff", rdata_out); end
        n_checks++; if (mem[16'h2004] !== 16'hA534) begin n_fail++; $display("[TB] FAIL stb_memory: got %h expected a534", mem[16'h2004]); end
    endtask

    task automatic test_ldi;
        mem[16'h4000] = 16'h5002;
        mem[16'h5002] = 16'h00AA;
        run_access(3'b011, 16'h4000, 16'h0000, 1, 0);
        n_checks++; if (r_first_addr !== 16'h4000) begin n_fail++; $display("[TB] FAIL ldi_first_addr: got %h expected 4000", r_first_addr); end
        n_checks++; if (r_last_addr !== 16'h5002) begin n_fail++; $display("[TB] FAIL ldi_second_addr: got %h expected 5002", r_last_addr); end
        n_checks++; if (rdata_out !== 16'h00AA) begin n_fail++; $display("[TB] FAIL ldi_rdata: got %h expected 00aa", rdata_out); end
        n_checks++; if (addr_out !== 16'h5002) begin n_fail++; $display("[TB] FAIL ldi_addr_out: got %h expected 5002", addr_out); end
        n_checks++; if (r_stall !== 5 || r_done !== 1) begin n_fail++; $display("[TB] FAIL ldi_timing: got stall %0d done %0d expected 5 1", r_stall, r_done); end
    endtask

    task automatic test_sti_reset;
        bit in_acc2 = 0;
        int dones = 0;
        mem[16'h7000] = 16'h7100;
        mem[16'h7100] = 16'h1111;
        resp_delay = 3;
        @(negedge clk);
        req_valid = 1'b1; op = 3'b110; addr_in = 16'h7000; wdata_in = 16'h9999;
        for (int c = 0; c < 40 && !in_acc2; c++) begin
            #1;
            if (mem_write) in_acc2 = 1;
            else @(negedge clk);
        end
        n_checks++; if (!in_acc2) begin n_fail++; $display("[TB] FAIL sti_second_access: got no mem_write expected mem_write"); end
        rst_n = 1'b0; req_valid = 1'b0; op = 3'b000;
        #1;
        n_checks++; if ({mem_read, mem_write, done, mem_byte_enable} !== 5'b0) begin n_fail++; $display("[TB] FAIL sti_reset_ctrl: got %b expected 00000", {mem_read, mem_write, done, mem_byte_enable}); end
        n_checks++; if ({rdata_out, ldb_out, addr_out, mem_address, mem_wdata} !== 80'h0) begin n_fail++; $display("[TB] FAIL sti_reset_data: got %h %h %h %h %h expected all zero", rdata_out, ldb_out, addr_out, mem_address, mem_wdata); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (done) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("[TB] FAIL sti_abandoned_done: got %0d expected 0", dones); end
        n_checks++; if (mem[16'h7100] !== 16'h1111) begin n_fail++; $display("[TB] FAIL sti_abandoned_write: got %h expected 1111", mem[16'h7100]); end
        mem[16'h6000] = 16'h1357;
        run_access(3'b001, 16'h6000, 16'h0000, 0, 0);
        n_checks++; if (rdata_out !== 16'h1357 || r_done !== 1 || r_stall !== 2) begin n_fail++; $display("[TB] FAIL post_reset_ldw: got %h done %0d stall %0d expected 1357 1 2", rdata_out, r_done, r_stall); end
        exp_rdata = 16'h1357;
        exp_ldb = 16'h0000;
    endtask

    task automatic test_nop;
        logic [2:0] nops [2];
        nops[0] = 3'b000; nops[1] = 3'b111;
        for (int k = 0; k < 2; k++) begin
            int stalls = 0, reqs = 0, dones = 0;
            @(negedge clk);
            req_valid = 1'b1; op = nops[k]; addr_in = 16'h1234; spurious = 1;
            for (int c = 0; c < 6; c++) begin
                #1;
                if (stall) stalls++;
                if (mem_read || mem_write) reqs++;
                if (done) dones++;
                @(negedge clk);
            end
            spurious = 0; req_valid = 1'b0; op = 3'b000;
            n_checks++; if (stalls !== 0 || reqs !== 0 || dones !== 0) begin n_fail++; $display("[TB] FAIL nop_op%0d: got stall %0d req %0d done %0d expected 0 0 0", nops[k], stalls, reqs, dones); end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  o;
            logic [15:0] a, w, a1, fin, word, exp_mem;
            logic [7:0]  b;
            logic [1:0]  exp_be;
            bit          is_word, is_store;
            int          d, nacc;
            o = 3'($urandom_range(1, 6));
            a = 16'($urandom); w = 16'($urandom);
            d = $urandom_range(0, 3);
            is_word  = (o == 3'd1) || (o == 3'd3) || (o == 3'd4) || (o == 3'd6);
            is_store = (o >= 3'd4);
            a1 = is_word ? {a[15:1], 1'b0} : a;
            exp_be = is_word ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
            word = mem[a1];
            fin = a1; nacc = 1; exp_mem = 16'h0;
            case (o)
                3'd1: exp_rdata = word;
                3'd2: begin
                    exp_rdata = word;
                    b = a1[0] ? word[15:8] : word[7:0];
                    exp_ldb = {{8{b[7]}}, b};
                end
                3'd3: begin fin = {word[15:1], 1'b0}; nacc = 2; exp_rdata = mem[fin]; end
                3'd4: exp_mem = w;
                3'd5: exp_mem = a1[0] ? {w[7:0], word[7:0]} : {word[15:8], w[7:0]};
                default: begin fin = {word[15:1], 1'b0}; nacc = 2; exp_mem = w; end
            endcase
            run_access(o, a, w, d, 1);
            n_checks++; if (r_timeout || r_done !== 1) begin n_fail++; $display("[TB] FAIL rnd%0d_done: got %0d pulses expected 1 (op %0d)", i, r_done, o); end
            n_checks++; if (r_stall !== 1 + nacc * (d + 1)) begin n_fail++; $display("[TB] FAIL rnd%0d_stall: got %0d expected %0d", i, r_stall, 1 + nacc * (d + 1)); end
            n_checks++; if (addr_out !== fin || r_last_addr !== fin) begin n_fail++; $display("[TB] FAIL rnd%0d_addr: got %h/%h expected %h", i, addr_out, r_last_addr, fin); end
            n_checks++; if (r_last_be !== exp_be) begin n_fail++; $display("[TB] FAIL rnd%0d_be: got %b expected %b", i, r_last_be, exp_be); end
            n_checks++; if (rdata_out !== exp_rdata || ldb_out !== exp_ldb) begin n_fail++; $display("[TB] FAIL rnd%0d_load: got %h %h expected %h %h", i, rdata_out, ldb_out, exp_rdata, exp_ldb); end
            n_checks++; if (r_saw_write !== is_store) begin n_fail++; $display("[TB] FAIL rnd%0d_write_seen: got %0d expected %0d", i, r_saw_write, is_store); end
            if (is_store) begin
                n_checks++; if (mem[fin] !== exp_mem) begin n_fail++; $display("[TB] FAIL rnd%0d_memory: got %h expected %h", i, mem[fin], exp_mem); end
            end
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no completion expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        test_reset();
        test_ldw();
        test_ldb();
        test_stb();
        test_ldi();
        test_sti_reset();
        test_nop();
        test_random();
        n_checks++; if (viol !== 0) begin n_fail++; $display("[TB] FAIL protocol_violations: got %0d expected 0", viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
